// File: rtl/membership_bit_serializer.sv
// membership_bit_serializer: latches five membership degrees and streams them MSB-first
// to a downstream comparator, capturing the winning index (or a tie) when the stream ends.
module membership_bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits_0,
  input  logic [WIDTH-1:0] io_in_bits_1,
  input  logic [WIDTH-1:0] io_in_bits_2,
  input  logic [WIDTH-1:0] io_in_bits_3,
  input  logic [WIDTH-1:0] io_in_bits_4,
  output logic             io_start,
  output logic             io_outputs_0,
  output logic             io_outputs_1,
  output logic             io_outputs_2,
  output logic             io_outputs_3,
  output logic             io_outputs_4,
  input  logic             io_resultValid,
  input  logic [2:0]       io_result,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [2:0]       io_out_index,
  output logic             io_out_tie,
  output logic             io_busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;
  state_e                state_q, state_d;
  logic [4:0][WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic                  tie_q, tie_d;
  logic                  last;
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tie_d   = tie_q;
    case (state_q)
      IDLE: if (io_in_valid) begin
        sr_d    = {io_in_bits_4, io_in_bits_3, io_in_bits_2, io_in_bits_1, io_in_bits_0};
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        cnt_d = cnt_q + CW'(1);
        for (int k = 0; k < 5; k++) sr_d[k] = sr_q[k] << 1;
        if (io_resultValid || last) begin
          idx_d   = io_result;
          tie_d   = !io_resultValid;
          state_d = DONE;
        end
      end
      DONE:    state_d = io_out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tie_q   <= tie_d;
    end
  end
  // the current bit is always the MSB because the registers shift left each cycle
  assign io_in_ready  = state_q == IDLE;
  assign io_start     = state_q == STREAM;
  assign io_out_valid = state_q == DONE;
  assign io_busy      = state_q != IDLE;
  assign io_outputs_0 = io_start & sr_q[0][WIDTH-1];
  assign io_outputs_1 = io_start & sr_q[1][WIDTH-1];
  assign io_outputs_2 = io_start & sr_q[2][WIDTH-1];
  assign io_outputs_3 = io_start & sr_q[3][WIDTH-1];
  assign io_outputs_4 = io_start & sr_q[4][WIDTH-1];
  assign io_out_index = idx_q;
  assign io_out_tie   = tie_q;
endmodule

// File: tb/tb_membership_bit_serializer.sv
// tb_membership_bit_serializer: randomized and directed checks of the bit serializer
// against a comparator model that resolves the maximum from value prefixes.
module tb_membership_bit_serializer;
  localparam int W = 8;
  logic         clock = 1'b0;
  logic         reset, io_in_valid, io_in_ready, io_start, io_resultValid, io_out_valid;
  logic         io_out_ready, io_out_tie, io_busy;
  logic         io_outputs_0, io_outputs_1, io_outputs_2, io_outputs_3, io_outputs_4;
  logic [W-1:0] io_in_bits_0, io_in_bits_1, io_in_bits_2, io_in_bits_3, io_in_bits_4;
  logic [2:0]   io_result, io_out_index;
  logic [4:0]   outs;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clock = ~clock;
  assign outs = {io_outputs_4, io_outputs_3, io_outputs_2, io_outputs_1, io_outputs_0};

  membership_bit_serializer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_0(io_in_bits_0), .io_in_bits_1(io_in_bits_1), .io_in_bits_2(io_in_bits_2),
    .io_in_bits_3(io_in_bits_3), .io_in_bits_4(io_in_bits_4), .io_start(io_start),
    .io_outputs_0(io_outputs_0), .io_outputs_1(io_outputs_1), .io_outputs_2(io_outputs_2),
    .io_outputs_3(io_outputs_3), .io_outputs_4(io_outputs_4), .io_resultValid(io_resultValid),
    .io_result(io_result), .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_index(io_out_index), .io_out_tie(io_out_tie), .io_busy(io_busy)
  );

  // Downstream comparator model: resolves at the first bit where one prefix is strictly largest.
  function automatic void model(input logic [4:0][W-1:0] v, output int rj, output logic [2:0] idx);
    rj = -1;
    idx = 3'd0;
    for (int j = 0; j < W; j++) begin
      int m, c, a, p;
      m = -1; c = 0; a = 0;
      for (int k = 0; k < 5; k++) begin
        p = int'(v[k] >> (W - 1 - j));
        if (p > m) begin m = p; c = 1; a = k; end
        else if (p == m) c++;
      end
      idx = 3'(a);
      if (c == 1) begin rj = j; return; end
    end
  endfunction

  task automatic scramble_bits();
    {io_in_bits_4, io_in_bits_3, io_in_bits_2, io_in_bits_1, io_in_bits_0} = {$urandom, $urandom};
  endtask

  // Runs one set from the accept cycle to the DONE handshake; starts and ends at posedge+1.
  task automatic run_stream(input logic [4:0][W-1:0] v, input int rj, input logic [2:0] res,
                            input int stall, input bit hold, input string tag);
    logic [4:0] exp_bits;
    bit         exp_tie;
    int         j;
    {io_in_bits_4, io_in_bits_3, io_in_bits_2, io_in_bits_1, io_in_bits_0} = v;
    io_in_valid = 1'b1; io_resultValid = 1'b0; io_out_ready = 1'b0;
    @(negedge clock);
    n_checks++;
    if (io_in_ready !== 1'b1 || io_busy !== 1'b0 || io_start !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: ready=%b busy=%b start=%b, want 1 0 0", tag, io_in_ready, io_busy, io_start);
    end
    @(posedge clock); #1;
    io_in_valid = hold;
    if (hold) scramble_bits();
    j = 0;
    forever begin
      io_resultValid = (j == rj);
      io_result = res;
      @(negedge clock);
      for (int k = 0; k < 5; k++) exp_bits[k] = v[k][W-1-j];
      n_checks++;
      if (io_start !== 1'b1 || io_in_ready !== 1'b0 || io_out_valid !== 1'b0 || io_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s stream_ctl j=%0d: start=%b ready=%b valid=%b busy=%b, want 1 0 0 1",
                 tag, j, io_start, io_in_ready, io_out_valid, io_busy);
      end
      n_checks++;
      if (outs !== exp_bits) begin
        n_fail++;
        $display("FAIL %s stream_bits j=%0d: got %b want %b", tag, j, outs, exp_bits);
      end
      @(posedge clock); #1;
      if (j == rj || j == W - 1) break;
      j++;
      if (hold) scramble_bits();
    end
    exp_tie = (rj != j);
    io_resultValid = 1'b1;
    io_result = ~res;
    for (int s = 0; s <= stall; s++) begin
      io_out_ready = (s == stall);
      @(negedge clock);
      n_checks++;
      if (io_out_valid !== 1'b1 || io_out_index !== res || io_out_tie !== exp_tie) begin
        n_fail++;
        $display("FAIL %s done s=%0d: valid=%b index=%0d tie=%b, want 1 %0d %b",
                 tag, s, io_out_valid, io_out_index, io_out_tie, res, exp_tie);
      end
      n_checks++;
      if (io_in_ready !== 1'b0 || io_start !== 1'b0 || outs !== 5'b0 || io_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s done_ctl s=%0d: ready=%b start=%b outs=%b busy=%b, want 0 0 00000 1",
                 tag, s, io_in_ready, io_start, outs, io_busy);
      end
      @(posedge clock); #1;
      if (hold) scramble_bits();
    end
    io_out_ready = 1'b0;
    io_resultValid = 1'b0;
    if (!hold) begin
      io_in_valid = 1'b0;
      @(negedge clock);
      n_checks++;
      if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1 || io_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s post_idle: valid=%b ready=%b busy=%b, want 0 1 0", tag, io_out_valid, io_in_ready, io_busy);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; io_in_valid = 1'b1; io_resultValid = 1'b1; io_result = 3'd3; io_out_ready = 1'b0;
    scramble_bits();
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (io_in_ready !== 1'b1 || io_start !== 1'b0 || outs !== 5'b0 || io_out_valid !== 1'b0 ||
        io_out_index !== 3'd0 || io_out_tie !== 1'b0 || io_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b start=%b outs=%b valid=%b index=%0d tie=%b busy=%b",
               io_in_ready, io_start, outs, io_out_valid, io_out_index, io_out_tie, io_busy);
    end
    @(posedge clock); #1;
    reset = 1'b0; io_in_valid = 1'b0; io_resultValid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (io_start !== 1'b0 || io_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept: start=%b busy=%b, want 0 0", io_start, io_busy);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_basic_stream();
    run_stream({8'h7F, 8'h01, 8'h30, 8'hA5, 8'h12}, -1, 3'd4, 0, 1'b0, "basic");
  endtask

  task automatic test_early_resolve();
    run_stream({8'h7F, 8'h01, 8'h30, 8'hA5, 8'h12}, 0, 3'd1, 0, 1'b0, "early");
  endtask

  task automatic test_lsb_resolve();
    run_stream({8'h00, 8'h00, 8'h00, 8'h03, 8'h02}, W - 1, 3'd1, 0, 1'b0, "lsb");
  endtask

  task automatic test_backpressure();
    run_stream({8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 3, 3'd6, 5, 1'b0, "backpressure");
  endtask

  task automatic test_back_to_back();
    run_stream({8'h01, 8'h02, 8'h04, 8'h08, 8'h10}, 3, 3'd4, 0, 1'b1, "b2b_first");
    run_stream({8'hFF, 8'h80, 8'h40, 8'h20, 8'h10}, -1, 3'd2, 0, 1'b1, "b2b_second");
    io_in_valid = 1'b0;
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++;
    if (io_in_ready !== 1'b1 || io_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: ready=%b busy=%b, want 1 0", io_in_ready, io_busy);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_stream();
    run_stream({8'h00, 8'h00, 8'h00, 8'h55, 8'h55}, -1, 3'd5, 0, 1'b0, "pre_reset");
    {io_in_bits_4, io_in_bits_3, io_in_bits_2, io_in_bits_1, io_in_bits_0} = {5{8'hFF}};
    io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1; io_in_valid = 1'b1; io_resultValid = 1'b1; io_result = 3'd3;
    @(posedge clock); #1;
    reset = 1'b0; io_in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_checks++;
      if (io_start !== 1'b0 || io_in_ready !== 1'b1 || io_out_valid !== 1'b0 ||
          io_out_index !== 3'd0 || io_out_tie !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid c=%0d: start=%b ready=%b valid=%b index=%0d tie=%b, want 0 1 0 0 0",
                 c, io_start, io_in_ready, io_out_valid, io_out_index, io_out_tie);
      end
      @(posedge clock); #1;
    end
    io_resultValid = 1'b0;
  endtask

  task automatic test_end_to_end();
    logic [4:0][W-1:0] v;
    int rj;
    logic [2:0] idx;
    v = {8'h08, 8'h40, 8'hC0, 8'h20, 8'h10};
    model(v, rj, idx);
    run_stream(v, rj, idx, 0, 1'b0, "e2e");
  endtask

  task automatic test_random();
    logic [4:0][W-1:0] v;
    logic [7:0] pool [3];
    int rj;
    logic [2:0] idx;
    pool[0] = 8'h00; pool[1] = 8'h5A; pool[2] = 8'hF0;
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 5; k++) v[k] = ($urandom_range(1) == 0) ? W'($urandom) : pool[$urandom_range(2)];
      model(v, rj, idx);
      run_stream(v, rj, idx, $urandom_range(3), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_early_resolve();
    test_lsb_resolve();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_stream();
    test_end_to_end();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/membership_bit_serializer.md
MEMBERSHIP_BIT_SERIALIZER -- requirements
Module: membership_bit_serializer

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 8, giving the bit width of each membership value and the stream length in cycles.
REQ-002 The block SHALL have one clock, reset is synchronous and active-high.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 io_in_valid  in  1  parallel membership set offered.
REQ-006 io_in_ready  out  1  block accepts a set this cycle.
REQ-007 io_in_bits_0..io_in_bits_4  in  WIDTH each  unsigned membership degrees, index 0..4.
REQ-008 io_start  out  1  stream active; drives the fuzzification start input.
REQ-009 io_outputs_0..io_outputs_4  out  1 each  current serial bit per membership, MSB first.
REQ-010 io_resultValid  in  1  max index resolved by downstream comparator.
REQ-011 io_result  in  3  downstream max index, 0..4.
REQ-012 io_out_valid  out  1  captured index available.
REQ-013 io_out_ready  in  1  consumer takes captured index.
REQ-014 io_out_index  out  3  captured winning index.
REQ-015 io_out_tie  out  1  stream finished without io_resultValid.
REQ-016 io_busy  out  1  high in any state other than IDLE.

Function
REQ-017 The block SHALL implement states IDLE, STREAM, DONE.
REQ-018 IDLE: io_in_ready=1, io_start=0, io_outputs_*=0, io_out_valid=0.
REQ-019 On io_in_valid&&io_in_ready, the block SHALL latch all five values into shift registers, clear the bit counter to 0 and enter STREAM next cycle.
REQ-020 STREAM: io_start=1, io_in_ready=0, io_outputs_k = bit (WIDTH-1-counter) of value k, i.e. MSB in first STREAM cycle, LSB in cycle WIDTH.
REQ-021 Each STREAM cycle the counter SHALL increment by 1 and every shift register SHALL shift left by one, zero fill.
REQ-022 In any STREAM cycle where io_resultValid=1, the block SHALL capture io_result into io_out_index, clear io_out_tie, and enter DONE next cycle (early termination; remaining bits not sent).
REQ-023 In the STREAM cycle with counter=WIDTH-1 and io_resultValid=0, the block SHALL capture io_result, set io_out_tie=1, and enter DONE next cycle.
REQ-024 io_resultValid SHALL be ignored in IDLE and DONE.
REQ-025 DONE: io_start=0, io_outputs_*=0, io_out_valid=1, io_out_index and io_out_tie held stable until handshake.
REQ-026 On io_out_valid&&io_out_ready, the block SHALL enter IDLE next cycle; io_out_valid SHALL NOT be combinationally dependent on io_out_ready.
REQ-027 Minimum latency SHALL be: accept at cycle T, first bit at T+1, io_out_valid at T+1+j+1 where j is the 0-based bit cycle of resolution; maximum io_out_valid at T+WIDTH+1.
REQ-028 No new set SHALL be accepted while io_busy=1; io_in_valid held high in STREAM/DONE has no effect.
REQ-029 Accept-to-accept throughput SHALL be at least one set per WIDTH+2 cycles with io_out_ready held high.

Reset
REQ-030 While reset=1 the block SHALL enter IDLE and clear shift registers, counter, io_out_index, io_out_tie; outputs SHALL read io_in_ready=1 (after reset), io_start=0, io_outputs_*=0, io_out_valid=0, io_out_index=0, io_out_tie=0, io_busy=0.
REQ-031 Reset asserted mid-STREAM or in DONE SHALL abandon the operation; no io_out_valid SHALL follow for the abandoned set.
REQ-032 A set offered in the same cycle as reset SHALL NOT be accepted.

Verification
REQ-033 Basic stream: WIDTH=8, values {0x12,0xA5,0x30,0x01,0x7F}, io_resultValid=0 -> bit k on io_outputs_1 reads 1,0,1,0,0,1,0,1 over 8 cycles, io_start high exactly 8 cycles, then io_out_valid=1, io_out_tie=1.
REQ-034 Early resolve: io_resultValid=1 with io_result=1 in 1st STREAM cycle -> io_start high 1 cycle, io_out_index=1, io_out_tie=0, io_out_valid at T+2.
REQ-035 Backpressure: io_out_ready=0 for 5 cycles in DONE -> io_out_valid, io_out_index stable, io_in_ready=0 throughout; IDLE one cycle after io_out_ready=1.
REQ-036 Back-to-back: io_in_valid held high with two sets, io_out_ready=1 -> second accept exactly one cycle after first DONE handshake, no bit overlap.
REQ-037 Reset at 4th STREAM cycle -> next cycle io_start=0, io_in_ready=1, no io_out_valid pulse.
REQ-038 End-to-end with fuzzification stage: values {0x10,0x20,0xC0,0x40,0x08} -> io_out_index=2, io_out_tie=0.
